// File: rtl/debounce_scheduler.sv
// Debounce scheduler: shares one external settle timer among N_BTN buttons,
// granting it round-robin and publishing debounced levels and edge pulses.
module debounce_scheduler #(
  parameter int N_BTN       = 4,
  parameter int SYNC_STAGES = 2,
  localparam int IW = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             timer_done,
  output logic             timer_start,
  output logic [N_BTN-1:0] btn_stable,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             busy,
  output logic [IW-1:0]    grant_idx
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    CHECK
  } state_t;

  state_t           state;
  logic [N_BTN-1:0] sync_q [SYNC_STAGES];
  logic [N_BTN-1:0] btn_sync;
  logic [N_BTN-1:0] pending;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    pick;
  logic             pick_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= btn_raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign btn_sync = sync_q[SYNC_STAGES-1];
  assign pending  = btn_sync ^ btn_stable;
  assign busy     = (state != IDLE);

  // Scan from the far end so the closest pending index to rr_ptr wins.
  always_comb begin
    int idx;
    pick     = rr_ptr;
    pick_vld = 1'b0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_BTN) idx = idx - N_BTN;
      if (pending[IW'(idx)]) begin
        pick     = IW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant_idx   <= '0;
      rr_ptr      <= '0;
      timer_start <= 1'b0;
      btn_stable  <= '0;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      timer_start <= 1'b0;
      btn_press   <= '0;
      btn_release <= '0;
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            grant_idx   <= pick;
            timer_start <= 1'b1;
            state       <= START;
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (timer_done) state <= CHECK;
        end
        CHECK: begin
          if (pending[grant_idx]) begin
            btn_stable[grant_idx] <= btn_sync[grant_idx];
            if (btn_sync[grant_idx]) btn_press[grant_idx] <= 1'b1;
            else btn_release[grant_idx] <= 1'b1;
          end
          rr_ptr <= (grant_idx == IW'(N_BTN - 1)) ? '0
                                                  : grant_idx + IW'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_scheduler.sv
// Bench for debounce_scheduler: directed scenarios plus random button
// activity, checked every cycle against a timestamp-based reference model.
module tb_debounce_scheduler;

  localparam int N  = 4;
  localparam int S  = 2;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  btn_raw = '0;
  logic          timer_done = 1'b0;
  logic          timer_start;
  logic [N-1:0]  btn_stable;
  logic [N-1:0]  btn_press;
  logic [N-1:0]  btn_release;
  logic          busy;
  logic [IW-1:0] grant_idx;

  always #5 clk = ~clk;

  debounce_scheduler #(.N_BTN(N), .SYNC_STAGES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .timer_done  (timer_done),
    .timer_start (timer_start),
    .btn_stable  (btn_stable),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .busy        (busy),
    .grant_idx   (grant_idx)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: owner + grant/done timestamps, raw history queue.
  logic [N-1:0] hist[$];
  logic [N-1:0] m_stable, m_press, m_rel;
  bit           m_start;
  int           owner, t_grant, t_done, rr, m_grant, cyc;

  function automatic void m_clear();
    hist.delete();
    for (int i = 0; i < S; i++) hist.push_back('0);
    m_stable = '0;
    m_press  = '0;
    m_rel    = '0;
    m_start  = 1'b0;
    owner    = -1;
    t_grant  = 0;
    t_done   = -1;
    rr       = 0;
    m_grant  = 0;
  endfunction

  function automatic void model_edge();
    logic [N-1:0] pend;
    int j;
    pend    = hist[0] ^ m_stable;
    m_press = '0;
    m_rel   = '0;
    m_start = 1'b0;
    cyc++;
    if (rst) begin
      m_clear();
      return;
    end
    if (owner < 0) begin
      for (int k = 0; k < N; k++) begin
        j = (rr + k) % N;
        if (owner < 0 && pend[j[IW-1:0]]) owner = j;
      end
      if (owner >= 0) begin
        t_grant = cyc;
        t_done  = -1;
        m_start = 1'b1;
        m_grant = owner;
      end
    end else if (t_done < 0) begin
      if (timer_done && cyc >= t_grant + 2) t_done = cyc;
    end else begin
      if (pend[owner[IW-1:0]]) begin
        m_stable[owner[IW-1:0]] = ~m_stable[owner[IW-1:0]];
        if (m_stable[owner[IW-1:0]]) m_press[owner[IW-1:0]] = 1'b1;
        else m_rel[owner[IW-1:0]] = 1'b1;
      end
      rr    = (owner + 1) % N;
      owner = -1;
    end
    void'(hist.pop_front());
    hist.push_back(btn_raw);
  endfunction

  function automatic bit quiet();
    bit q;
    q = (owner < 0) && (btn_raw == m_stable);
    foreach (hist[i]) if (hist[i] != m_stable) q = 1'b0;
    return q;
  endfunction

  task automatic compare();
    check("busy", busy, owner >= 0);
    check("timer_start", timer_start, m_start);
    check("btn_stable", btn_stable, m_stable);
    check("btn_press", btn_press, m_press);
    check("btn_release", btn_release, m_rel);
    if (owner >= 0) check("grant_idx", grant_idx, m_grant);
  endtask

  int           tcnt = 0;
  int           lat_lo = 20;
  int           lat_hi = 20;
  bit           spur = 1'b0;
  logic [IW-1:0] grants[$];

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    if (timer_start) grants.push_back(grant_idx);
    timer_done = 1'b0;
    if (tcnt > 0) begin
      tcnt--;
      if (tcnt == 0) timer_done = 1'b1;
    end
    if (timer_start) tcnt = $urandom_range(lat_hi, lat_lo);
    if (spur && $urandom_range(0, 60) == 0) timer_done = 1'b1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    m_clear();
    #1;
    compare();
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic run_quiet(input string tag, input int max);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!quiet() && n < max);
    check(tag, quiet(), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cyc = 0;
    m_clear();
    btn_raw = 4'b1111;
    #2;
    do_reset(3);
    grants.delete();
    run_quiet("s1_settle", 600);
    check("s1_grant_count", grants.size(), 4);
    for (int k = 0; k < 4 && k < grants.size(); k++)
      check("s1_grant_order", grants[k], k);

    btn_raw = '0;
    do_reset(2);
    btn_raw = 4'b0100;
    run_quiet("s2_settle", 300);
    check("s2_stable", btn_stable, 4'b0100);

    btn_raw = 4'b0110;
    repeat (5) tick();
    btn_raw = 4'b0100;
    run_quiet("s3_settle", 300);
    check("s3_stable", btn_stable, 4'b0100);

    btn_raw = 4'b0000;
    timer_done = 1'b1;
    run_quiet("s5_settle", 300);
    check("s5_stable", btn_stable, 4'b0000);

    btn_raw = 4'b0001;
    for (int n = 0; n < 50; n++) begin
      if (owner >= 0 && cyc >= t_grant + 4) break;
      tick();
    end
    check("s6_in_wait", busy, 1);
    do_reset(2);
    run_quiet("s6_settle", 300);
    check("s6_stable", btn_stable, 4'b0001);

    lat_lo = 30;
    lat_hi = 2;
    spur   = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 19) == 0)
        btn_raw[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 1499) == 0) do_reset($urandom_range(1, 3));
      else tick();
    end
    spur = 1'b0;
    run_quiet("rand_settle", 800);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
